// File: rtl/branch_resolve_unit.sv
// Branch resolution: carries fetch-time predictions down to execute, detects mispredicts,
// redirects fetch and trains the predictor. Define BRU_PERF_CNT_EN to add performance counters.
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  valid_f,
    input  logic                  predict_taken_f,
    input  logic [DATA_WIDTH-1:0] PC_f,
    input  logic [DATA_WIDTH-1:0] branch_target_f,
    input  logic                  is_branch_e,
    input  logic                  is_jal_e,
    input  logic                  actual_taken_e,
    input  logic [DATA_WIDTH-1:0] PC_e,
    input  logic [DATA_WIDTH-1:0] actual_target_e,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  upd_valid,
    output logic [DATA_WIDTH-1:0] upd_pc,
    output logic                  upd_taken,
    output logic [DATA_WIDTH-1:0] upd_target,
    output logic                  upd_uncond
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]           mispredict_cnt,
    output logic [31:0]           branch_cnt
`endif
);

    typedef enum logic {
        S_RUN     = 1'b0,
        S_RECOVER = 1'b1
    } state_t;

    state_t                state_q;

    logic                  vld_p1_q, vld_p2_q;
    logic                  vld_p1_d, vld_p2_d;
    logic                  pt_p1_q, pt_p2_q;
    logic [DATA_WIDTH-1:0] tgt_p1_q, tgt_p2_q;

    logic                  upd_valid_q, upd_taken_q, upd_uncond_q;
    logic [DATA_WIDTH-1:0] upd_pc_q, upd_target_q;

    logic                  is_ctl;
    logic                  resolve;
    logic                  mispredict;
    logic                  upd_load;
    logic [DATA_WIDTH-1:0] pc_plus4;

    // Fetch PC is not needed: the execute stage supplies its own PC.
    logic                  unused_pc_f;
    assign unused_pc_f = ^PC_f;

    // A non-control instruction that was predicted taken is an alias hit and always wrong.
    function automatic logic mispredict_f(
        input logic                  ctl,
        input logic                  pred_taken,
        input logic [DATA_WIDTH-1:0] pred_tgt,
        input logic                  taken,
        input logic [DATA_WIDTH-1:0] tgt
    );
        if (!ctl) begin
            return pred_taken;
        end
        return (pred_taken != taken) || (pred_taken && taken && (pred_tgt != tgt));
    endfunction

    // ---- F -> D -> E prediction pipeline ----
    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        if (flush) begin
            vld_p1_d = 1'b0;
            vld_p2_d = 1'b0;
        end else if (!stall) begin
            vld_p1_d = valid_f;
            vld_p2_d = vld_p1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            pt_p1_q  <= predict_taken_f;
            tgt_p1_q <= branch_target_f;
            pt_p2_q  <= pt_p1_q;
            tgt_p2_q <= tgt_p1_q;
        end
    end

    // ---- E: resolution and redirect ----
    assign is_ctl     = is_branch_e | is_jal_e;
    assign resolve    = vld_p2_q && !stall && (state_q == S_RUN);
    assign mispredict = mispredict_f(is_ctl, pt_p2_q, tgt_p2_q, actual_taken_e, actual_target_e);
    assign pc_plus4   = PC_e + DATA_WIDTH'(4);

    assign redirect_valid = resolve && mispredict;
    assign redirect_pc    = resolve ? (actual_taken_e ? actual_target_e : pc_plus4) : '0;
    assign flush          = redirect_valid || (state_q == S_RECOVER);

    // One recovery cycle follows every redirect; nothing resolves while recovering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            case (state_q)
                S_RUN:     if (redirect_valid) state_q <= S_RECOVER;
                S_RECOVER: state_q <= S_RUN;
                default:   state_q <= S_RUN;
            endcase
        end
    end

    // ---- E -> predictor update port ----
    assign upd_load = resolve && is_ctl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            upd_target_q <= '0;
            upd_uncond_q <= 1'b0;
        end else begin
            upd_valid_q <= upd_load;
            if (upd_load) begin
                upd_pc_q     <= PC_e;
                upd_taken_q  <= actual_taken_e;
                upd_target_q <= actual_target_e;
                upd_uncond_q <= is_jal_e;
            end
        end
    end

    assign upd_valid  = upd_valid_q;
    assign upd_pc     = upd_pc_q;
    assign upd_taken  = upd_taken_q;
    assign upd_target = upd_target_q;
    assign upd_uncond = upd_uncond_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt_q, mispredict_cnt_q;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (upd_load)       branch_cnt_q     <= branch_cnt_q + 32'd1;
            if (redirect_valid) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a cycle-level reference model.
module tb_branch_resolve_unit;
    localparam int W = 32;

    logic         clk, rst, stall;
    logic         valid_f, predict_taken_f;
    logic [W-1:0] PC_f, branch_target_f;
    logic         is_branch_e, is_jal_e, actual_taken_e;
    logic [W-1:0] PC_e, actual_target_e;
    logic         flush, redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         upd_valid, upd_taken, upd_uncond;
    logic [W-1:0] upd_pc, upd_target;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]  mispredict_cnt, branch_cnt;
`endif

    branch_resolve_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .valid_f(valid_f), .predict_taken_f(predict_taken_f),
        .PC_f(PC_f), .branch_target_f(branch_target_f),
        .is_branch_e(is_branch_e), .is_jal_e(is_jal_e), .actual_taken_e(actual_taken_e),
        .PC_e(PC_e), .actual_target_e(actual_target_e),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_uncond(upd_uncond)
`ifdef BRU_PERF_CNT_EN
        , .mispredict_cnt(mispredict_cnt), .branch_cnt(branch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: prediction slots for D and E, recovery flag, last update, counters
    bit           m_v1, m_v2, m_p1, m_p2, m_rec;
    logic [W-1:0] m_t1, m_t2;
    bit           m_uv, m_ut, m_uu;
    logic [W-1:0] m_upc, m_utg;
    int unsigned  m_bc, m_mc;

    task automatic model_reset();
        m_v1 = 0; m_v2 = 0; m_p1 = 0; m_p2 = 0; m_rec = 0;
        m_t1 = '0; m_t2 = '0;
        m_uv = 0; m_ut = 0; m_uu = 0; m_upc = '0; m_utg = '0;
        m_bc = 0; m_mc = 0;
    endtask

    function automatic void calc(output bit res, output bit mis, output logic [W-1:0] npc);
        bit ctl;
        ctl = is_branch_e | is_jal_e;
        res = m_v2 && !stall && !m_rec;
        if (ctl) mis = (m_p2 != actual_taken_e) || (m_p2 && actual_taken_e && (m_t2 != actual_target_e));
        else     mis = m_p2;
        npc = actual_taken_e ? actual_target_e : PC_e + 32'd4;
    endfunction

    task automatic model_check();
        bit res, mis;
        logic [W-1:0] npc;
        calc(res, mis, npc);
        chk("flush", flush, (res && mis) || m_rec);
        chk("redirect_valid", redirect_valid, res && mis);
        if (res) chk("redirect_pc", redirect_pc, npc);
        chk("upd_valid", upd_valid, m_uv);
        chk("upd_pc", upd_pc, m_upc);
        chk("upd_taken", upd_taken, m_ut);
        chk("upd_target", upd_target, m_utg);
        chk("upd_uncond", upd_uncond, m_uu);
`ifdef BRU_PERF_CNT_EN
        chk("branch_cnt", branch_cnt, m_bc);
        chk("mispredict_cnt", mispredict_cnt, m_mc);
`endif
    endtask

    task automatic model_step();
        bit res, mis, rv, fl;
        logic [W-1:0] npc;
        calc(res, mis, npc);
        rv = res && mis;
        fl = rv || m_rec;
        if (res && (is_branch_e || is_jal_e)) begin
            m_uv = 1; m_upc = PC_e; m_ut = actual_taken_e; m_utg = actual_target_e; m_uu = is_jal_e;
            m_bc++;
        end else begin
            m_uv = 0;
        end
        if (rv) m_mc++;
        if (fl) begin
            m_v1 = 0; m_v2 = 0;
        end else if (!stall) begin
            m_v2 = m_v1; m_v1 = valid_f;
        end
        if (!stall) begin
            m_p2 = m_p1; m_t2 = m_t1; m_p1 = predict_taken_f; m_t1 = branch_target_f;
        end
        m_rec = rv;
    endtask

    // Inputs are applied at posedge+1; outputs are checked at the falling edge.
    task automatic settle();
        #4;
        model_check();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input bit v, input bit pt, input logic [W-1:0] tgt);
        valid_f = v; predict_taken_f = pt; branch_target_f = tgt; PC_f = $urandom;
    endtask

    task automatic set_e(input bit br, input bit jal, input bit tk, input logic [W-1:0] pc,
                         input logic [W-1:0] tgt);
        is_branch_e = br; is_jal_e = jal; actual_taken_e = tk; PC_e = pc; actual_target_e = tgt;
    endtask

    task automatic idle_inputs();
        stall = 0;
        set_f(0, 0, '0);
        set_e(0, 0, 0, '0, '0);
    endtask

    // Assert reset at posedge+1, check outputs immediately, release after the next edge.
    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_flush", flush, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_upd_pc", upd_pc, 0);
`ifdef BRU_PERF_CNT_EN
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_mispredict_cnt", mispredict_cnt, 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // Push one prediction into F and walk it to E (two edges).
    task automatic load_pred(input bit pt, input logic [W-1:0] tgt);
        set_f(1, pt, tgt); settle(); advance();
        set_f(0, 0, '0);   settle(); advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Beq predicted not-taken resolves taken
        load_pred(0, 32'h0);
        set_e(1, 0, 1, 32'h100, 32'h140);
        settle();
        chk("beq_flush", flush, 1);
        chk("beq_redirect_valid", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h140);
        advance();
        set_e(0, 0, 0, '0, '0);
        settle();
        chk("beq_upd_valid", upd_valid, 1);
        chk("beq_upd_pc", upd_pc, 32'h100);
        chk("beq_upd_taken", upd_taken, 1);
        chk("beq_recover_flush", flush, 1);
        chk("beq_redirect_once", redirect_valid, 0);
        advance();
        settle();
        chk("beq_flush_done", flush, 0);
        advance();

        // JAL correctly predicted
        load_pred(1, 32'h300);
        set_e(0, 1, 1, 32'h200, 32'h300);
        settle();
        chk("jal_flush", flush, 0);
        advance();
        set_e(0, 0, 0, '0, '0);
        settle();
        chk("jal_upd_valid", upd_valid, 1);
        chk("jal_upd_uncond", upd_uncond, 1);
        chk("jal_upd_pc", upd_pc, 32'h200);
`ifdef BRU_PERF_CNT_EN
        chk("jal_branch_cnt", branch_cnt, 2);
        chk("jal_mispredict_cnt", mispredict_cnt, 1);
`endif
        advance();

        // Alias hit on an ADD
        load_pred(1, 32'h999);
        set_e(0, 0, 0, 32'h80, 32'h0);
        settle();
        chk("alias_redirect_pc", redirect_pc, 32'h84);
        chk("alias_flush", flush, 1);
        advance();
        set_e(0, 0, 0, '0, '0);
        settle();
        chk("alias_upd_valid", upd_valid, 0);
        advance();
        settle(); advance();

        // Mispredict held back by stall
        load_pred(0, 32'h0);
        set_e(1, 0, 1, 32'h400, 32'h480);
        stall = 1;
        settle();
        chk("stall_flush", flush, 0);
        chk("stall_redirect_valid", redirect_valid, 0);
        advance();
        settle();
        chk("stall_hold_flush", flush, 0);
        advance();
        stall = 0;
        settle();
        chk("unstall_redirect_valid", redirect_valid, 1);
        chk("unstall_redirect_pc", redirect_pc, 32'h480);
        advance();
        idle_inputs(); settle(); advance();
        settle(); advance();

        // Back-to-back mispredicting branches: only the first redirects
        set_f(1, 0, '0); settle(); advance();
        set_f(1, 0, '0); settle(); advance();
        set_f(0, 0, '0);
        set_e(1, 0, 1, 32'h500, 32'h540);
        settle();
        chk("b2b_first_redirect", redirect_valid, 1);
        advance();
        set_e(1, 0, 1, 32'h504, 32'h580);
        settle();
        chk("b2b_second_ignored", redirect_valid, 0);
        chk("b2b_recover_flush", flush, 1);
        advance();
        settle();
        chk("b2b_no_late_redirect", redirect_valid, 0);
        advance();
        idle_inputs(); settle(); advance();

        // Reset in the middle of RECOVER with an update pending
        load_pred(0, 32'h0);
        set_e(1, 0, 1, 32'h600, 32'h640);
        settle();
        chk("rstrec_redirect", redirect_valid, 1);
        advance();
        idle_inputs();
        do_reset();
        settle();
        chk("rstrec_no_flush", flush, 0);
        chk("rstrec_no_upd", upd_valid, 0);
        advance();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] tset[4];
            bit jal, br;
            tset[0] = 32'h140; tset[1] = 32'h300; tset[2] = 32'h1000; tset[3] = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 255) == 0) begin
                idle_inputs();
                do_reset();
            end
            stall = ($urandom_range(0, 4) == 0);
            set_f($urandom_range(0, 9) < 7, $urandom_range(0, 1), tset[$urandom_range(0, 3)]);
            jal = ($urandom_range(0, 7) == 0);
            br  = !jal && $urandom_range(0, 1);
            set_e(br, jal, jal ? 1'b1 : (br ? 1'($urandom_range(0, 1)) : 1'b0),
                  ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                  tset[$urandom_range(0, 3)]);
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
